// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        unique case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = off[0];
            WORD:    bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh     = {off_i, 3'b000};
        lane   = word_i >> sh;
        load_o = word_i;
        mask   = 32'hffff_ffff;
        unique case (size_i)
            BYTE: begin
                load_o = {{24{lane[7] & ~uns_i}}, lane[7:0]};
                mask   = 32'h0000_00ff;
            end
            HALF: begin
                load_o = {{16{lane[15] & ~uns_i}}, lane[15:0]};
                mask   = 32'h0000_ffff;
            end
            default: begin
                load_o = word_i;
                mask   = 32'hffff_ffff;
            end
        endcase
        store_o = (word_i & ~(mask << sh))
                | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter and access sequencer.
// Define DMEM_ARB_RR_EN for round-robin arbitration (else fixed priority).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [2*NREQ-1:0]      req_size,
    input  logic [NREQ-1:0]        req_unsigned,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*32-1:0]     req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_dataW,
    input  logic [31:0]            mem_dataR,
    output logic                   mem_memR,
    output logic                   mem_memW
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_dataW_q;
    logic              memR_q;
    logic              memW_q;

    logic [NREQ-1:0]   grant;
    logic              found;
    logic              sel_we;
    logic              sel_uns;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       load_ext;
    logic [31:0]       store_word;

`ifdef DMEM_ARB_RR_EN
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    win_id;
`endif

    // Search starts at the pointer; without round-robin it is pinned to 0.
    always_comb begin
        int base;
`ifdef DMEM_ARB_RR_EN
        base   = int'(ptr_q);
        win_id = '0;
`else
        base   = 0;
`endif
        grant     = '0;
        found     = 1'b0;
        sel_we    = 1'b0;
        sel_uns   = 1'b0;
        sel_size  = 2'b00;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_valid[j]
                    && j == (base + k) % NREQ) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    sel_we    = req_we[j];
                    sel_uns   = req_unsigned[j];
                    sel_size  = req_size[2*j +: 2];
                    sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                    sel_wdata = req_wdata[j*32 +: 32];
`ifdef DMEM_ARB_RR_EN
                    win_id    = IDW'(j);
`endif
                end
            end
        end
    end

    dmem_lane_align u_align (
        .word_i  (mem_dataR),
        .wdata_i (wdata_q),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .load_o  (load_ext),
        .store_o (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_dataW_q <= '0;
            memR_q      <= 1'b0;
            memW_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_q   <= grant;
                        we_q    <= sel_we;
                        uns_q   <= sel_uns;
                        size_q  <= sel_size;
                        off_q   <= sel_addr[1:0];
                        wdata_q <= sel_wdata;
                        if (misaligned(sel_size, sel_addr[1:0])) begin
                            state_q     <= RESP;
                            rsp_valid_q <= grant;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
                            if (sel_we && sel_size == WORD) begin
                                state_q     <= WRITE;
                                memW_q      <= 1'b1;
                                mem_dataW_q <= sel_wdata;
                            end else begin
                                state_q <= READ;
                                memR_q  <= 1'b1;
                            end
                        end
`ifdef DMEM_ARB_RR_EN
                        ptr_q <= (int'(win_id) == NREQ - 1)
                               ? '0 : win_id + IDW'(1);
`endif
                    end
                end
                READ: begin
                    memR_q <= 1'b0;
                    if (we_q) begin
                        state_q     <= WRITE;
                        memW_q      <= 1'b1;
                        mem_dataW_q <= store_word;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= gnt_q;
                        rsp_rdata_q <= load_ext;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    memW_q      <= 1'b0;
                    mem_dataW_q <= '0;
                    rsp_valid_q <= gnt_q;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dataW = mem_dataW_q;
    assign mem_memR  = memR_q;
    assign mem_memW  = memW_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 12;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [2*NREQ-1:0]      req_size;
    logic [NREQ-1:0]        req_unsigned;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*32-1:0]     req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic                   rsp_err;
    logic [31:0]            rsp_rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic [31:0]            mem_dataW;
    logic [31:0]            mem_dataR;
    logic                   mem_memR;
    logic                   mem_memW;

    dmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_dataW    (mem_dataW),
        .mem_dataR    (mem_dataR),
        .mem_memR     (mem_memR),
        .mem_memW     (mem_memW)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:1023];
    always @(posedge clk) if (mem_memW) tb_mem[mem_addr[11:2]] <= mem_dataW;
    assign mem_dataR = mem_memR ? tb_mem[mem_addr[11:2]] : 32'h0;

    typedef struct {
        int          id;
        logic        we;
        logic [1:0]  sz;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] ref_mem [0:1023];
    int          acc_cnt [NREQ];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_memR = 0;
    int          n_rw_both = 0;
    int          n_addr_lo = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w,
        input logic [1:0] off, input logic [1:0] sz, input logic uns);
        logic [7:0] by [4];
        logic [31:0] v;
        by[0] = w[7:0];  by[1] = w[15:8];
        by[2] = w[23:16]; by[3] = w[31:24];
        v = w;
        if (sz == 2'b00)
            v = uns ? {24'h0, by[off]} : {{24{by[off][7]}}, by[off]};
        else if (sz == 2'b01)
            v = uns ? {16'h0, by[off+1], by[off]}
                    : {{16{by[off+1][7]}}, by[off+1], by[off]};
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w,
        input logic [1:0] off, input logic [1:0] sz, input logic [31:0] d);
        logic [7:0] by [4];
        by[0] = w[7:0];  by[1] = w[15:8];
        by[2] = w[23:16]; by[3] = w[31:24];
        if (sz == 2'b10) return d;
        by[off] = d[7:0];
        if (sz == 2'b01) by[off+1] = d[15:8];
        return {by[3], by[2], by[1], by[0]};
    endfunction

    function automatic exp_t predict(input int i);
        exp_t e;
        e.id      = i;
        e.we      = req_we[i];
        e.sz      = req_size[2*i +: 2];
        e.addr    = req_addr[i*ADDR_W +: ADDR_W];
        e.wd      = req_wdata[i*32 +: 32];
        e.acc_cyc = cyc;
        e.err     = (e.sz == 2'b11) || (e.sz == 2'b01 && e.addr[0])
                 || (e.sz == 2'b10 && e.addr[1:0] != 2'b00);
        e.rdata   = 32'h0;
        if (e.err) e.lat = 1;
        else if (e.we) e.lat = (e.sz == 2'b10) ? 2 : 3;
        else begin
            e.lat   = 2;
            e.rdata = ref_load(ref_mem[e.addr[11:2]], e.addr[1:0],
                               e.sz, req_unsigned[i]);
        end
        return e;
    endfunction

    // Runs once per cycle at the falling edge, away from DUT updates.
    task automatic monitor();
        exp_t e;
        cyc++;
        if (!rst_n) sb.delete();
        if (mem_memR) n_memR++;
        if (mem_memR && mem_memW) n_rw_both++;
        if (mem_addr[1:0] != 2'b00) n_addr_lo++;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) chk("rsp_spurious", 64'(rsp_valid), 0);
            else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_lat", 64'(cyc - e.acc_cyc), 64'(e.lat));
                if (e.we && !e.err)
                    ref_mem[e.addr[11:2]] = ref_store(ref_mem[e.addr[11:2]],
                        e.addr[1:0], e.sz, e.wd);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 1);
                grant_log.push_back(i);
                acc_cnt[i]++;
                sb.push_back(predict(i));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic we, input logic [1:0] sz,
        input logic uns, input logic [11:0] addr, input logic [31:0] wd);
        req_we[id]                  = we;
        req_size[2*id +: 2]         = sz;
        req_unsigned[id]            = uns;
        req_addr[id*ADDR_W +: ADDR_W] = addr;
        req_wdata[id*32 +: 32]      = wd;
        req_valid[id]               = 1'b1;
    endtask

    task automatic issue(input int id, input logic we, input logic [1:0] sz,
        input logic uns, input logic [11:0] addr, input logic [31:0] wd);
        int  start;
        logic ok;
        start = acc_cnt[id];
        ok    = 1'b0;
        set_req(id, we, sz, uns, addr, wd);
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (acc_cnt[id] != start) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid[id] = 1'b0;
        chk("accept", 64'(ok), 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && sb.size() != 0; n++) cycle();
        chk("idle_timeout", 64'(sb.size()), 0);
        cycle();
    endtask

    initial begin
        int   memr0;
        int   exp_g [4];
        logic got_w;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_we       = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        cycle();
        cycle();
        chk("reset_outs", {req_ready, rsp_valid, rsp_err, mem_memR, mem_memW,
                           mem_addr}, 0);
        chk("reset_rdata", 64'(rsp_rdata), 0);
        chk("reset_dataW", 64'(mem_dataW), 0);
        rst_n = 1'b1;
        cycle();

        issue(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        issue(1, 1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344);
        issue(1, 1'b1, 2'b00, 1'b0, 12'h013, 32'h0000005A);
        issue(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        issue(0, 1'b1, 2'b00, 1'b0, 12'h013, 32'hFFFFFF80);
        issue(0, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
        issue(1, 1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
        wait_idle();

        memr0 = n_memR;
        issue(1, 1'b0, 2'b01, 1'b0, 12'h011, 32'h0);
        wait_idle();
        chk("err_no_memR", 64'(n_memR - memr0), 0);

        issue(0, 1'b1, 2'b10, 1'b0, 12'h014, 32'h00000000);
        issue(1, 1'b1, 2'b01, 1'b0, 12'h016, 32'h1234BEEF);
        issue(0, 1'b0, 2'b01, 1'b0, 12'h016, 32'h0);
        issue(0, 1'b0, 2'b01, 1'b1, 12'h016, 32'h0);
        issue(1, 1'b0, 2'b00, 1'b0, 12'h012, 32'h0);
        issue(0, 1'b0, 2'b10, 1'b0, 12'h012, 32'h0);
        issue(1, 1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF);
        issue(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
        wait_idle();

        got_w = 1'b0;
        set_req(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'h12345678);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            monitor();
            if (mem_memW) begin
                got_w = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_write_seen", 64'(got_w), 1);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_memW", 64'(mem_memW), 0);
        chk("rst_outs", {req_ready, rsp_valid, rsp_err, mem_memR, mem_addr}, 0);
        chk("rst_rdata", 64'(rsp_rdata), 0);
        chk("rst_dataW", 64'(mem_dataW), 0);
        @(posedge clk);
        #1;
        chk("rst_no_write", 64'(tb_mem[8]), 64'h00000000CAFEF00D);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        grant_log.delete();
        set_req(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        set_req(1, 1'b0, 2'b01, 1'b0, 12'h016, 32'h0);
        for (int n = 0; n < 60 && grant_log.size() < 4; n++) cycle();
        req_valid = '0;
        chk("arb_count", 64'(grant_log.size()), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("arb_grant%0d", i), 64'(grant_log[i]),
                64'(exp_g[i]));
        wait_idle();

        issue(1, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
        wait_idle();

        chk("rw_exclusive", 64'(n_rw_both), 0);
        chk("addr_aligned", 64'(n_addr_lo), 0);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port byte-addressed data memory between `NREQ` requesters (load/store unit, debug/loader port) and sequences every access into the memory's `memR`/`memW` protocol. It accepts byte, halfword and word loads and stores, performs read-modify-write for sub-word stores, and sign- or zero-extends load data. It sits between the requesters and the data memory, and is the only block that drives the memory's control inputs.

## Interface
- `NREQ`, 2: number of requesters; index 0 has the highest fixed priority.
- `ADDR_W`, 12: byte-address width; equals the data memory `SIZE`.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NREQ: request present, one bit per requester.
- `req_ready`  out  NREQ: one-hot grant; request accepted on a clock edge where `valid&&ready`.
- `req_we`  in  NREQ: 1 = store, 0 = load.
- `req_size`  in  NREQ×2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  NREQ: load zero-extends when set.
- `req_addr`  in  NREQ×ADDR_W: byte address.
- `req_wdata`  in  NREQ×32: store data, right-aligned.
- `rsp_valid`  out  NREQ: one-cycle response strobe to the accepted requester.
- `rsp_err`  out  1: response is misaligned or illegal-size.
- `rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `mem_addr`  out  ADDR_W: word-aligned address, bits [1:0] always 0.
- `mem_dataW`  out  32: write word, little-endian (byte at addr+0 in [7:0]).
- `mem_dataR`  in  32: read word, valid while `mem_memR` is high.
- `mem_memR`  out  1: memory read enable.
- `mem_memW`  out  1: memory write enable, sampled by the memory on `posedge clk`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready` is combinational, one-hot to the winning valid requester; all other states hold `req_ready=0`.
  - On acceptance, latch the id, we, size, unsigned flag, address and wdata.
- Alignment check at acceptance:
  - Illegal when half and addr[0]=1, word and addr[1:0]≠0, or size=11.
  - Illegal requests go to RESP with `rsp_err=1` and no memory access.
- Load: READ (`mem_memR=1`; `mem_dataR` captured at the end of the cycle) → RESP. The lane is selected by addr[1:0], then sign- or zero-extended.
- Word store: WRITE (`mem_memW=1`, `mem_dataW=wdata`) → RESP.
- Sub-word store: READ → WRITE → RESP.
  - The WRITE word is the captured read word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - `mem_dataW` never carries X.
- RESP: `rsp_valid[id]=1` for exactly one cycle, then IDLE.
- `mem_memR` and `mem_memW` are never high together. Both are low in IDLE and RESP.

## Timing
- Reset values: state IDLE, every output 0, priority pointer at 0.
- Reset asserted mid-operation clears everything immediately. A WRITE in progress drops `mem_memW` before the edge, so no write occurs.
- Acceptance edge E0. Response cycle:
  - Load and word store: cycle after E1.
  - Sub-word store: cycle after E2.
  - Error: cycle after E0.
- Next acceptance is possible in the cycle after the response cycle, so throughput is one access per 3 cycles (4 for sub-word store).
- Requests arriving during a busy period wait. A requester holds `valid` and payload stable until accepted.
- Simultaneous valids: the arbitration rule selects one winner; the others see `ready=0`.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration. After each acceptance, the pointer moves to (winner+1) mod NREQ, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins, and the pointer logic is absent.

## Structure
- Package `dmem_pkg`:
  - `size_t` enum (BYTE, HALF, WORD) and `state_t` enum.
  - Misalignment check function.
- Sub-module `dmem_lane_align` (combinational):
  - Load extract/extend from word + addr[1:0] + size + unsigned.
  - Store merge from old word + wdata + addr[1:0] + size.
- The top module contains the FSM, arbiter and request latches.

## Test plan
- Store word 0xDEADBEEF at 0x010, then load word at 0x010.
  - `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, rsp one cycle after E1.
- Store byte 0x5A at 0x013 over 0x11223344, then load word at 0x010.
  - Result 0x5A223344; the store response comes 3 cycles after acceptance.
- Load byte signed at 0x013 (byte 0x80).
  - Result 0xFFFFFF80.
- Same load unsigned → 0x00000080.
- Load half at 0x011.
  - `rsp_err=1`, `rsp_rdata=0`, `mem_memR` never asserted, rsp the cycle after E0.
- Both requesters valid continuously, 4 accesses.
  - Fixed mode: grants 0,0,0,0.
  - `DMEM_ARB_RR_EN`: grants 0,1,0,1.
- `rst_n` driven low during WRITE of a store to 0x020.
  - `mem_memW` falls at once; location 0x020 is unchanged; all outputs are 0.
